// File: rtl/fft_pkg.sv
// Shared constants, sample/twiddle types and the Q10 twiddle generator for the 64-point FFT datapath.
package fft_pkg;

    localparam int N         = 64;
    localparam int DW        = 16;
    localparam int TW        = 18;
    localparam int TW_SHIFT  = 10;
    localparam int ROUND_ADD = 512;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW-1:0] re;
        logic signed [TW-1:0] im;
    } tw_t;

    // round(1024*cos(2*pi*i/64)) for the first quadrant, i = 0..16
    function automatic int qcos(input logic [4:0] i);
        case (i)
            5'd0:    return 1024;
            5'd1:    return 1019;
            5'd2:    return 1004;
            5'd3:    return 980;
            5'd4:    return 946;
            5'd5:    return 903;
            5'd6:    return 851;
            5'd7:    return 792;
            5'd8:    return 724;
            5'd9:    return 650;
            5'd10:   return 569;
            5'd11:   return 483;
            5'd12:   return 392;
            5'd13:   return 297;
            5'd14:   return 200;
            5'd15:   return 100;
            default: return 0;
        endcase
    endfunction

    function automatic tw_t twiddle(input logic [5:0] addr);
        tw_t w;
        int  c0, s0, cs, sn;
        c0 = qcos({1'b0, addr[3:0]});
        s0 = qcos(5'd16 - {1'b0, addr[3:0]});
        case (addr[5:4])
            2'd0:    begin cs = c0;  sn = s0;  end
            2'd1:    begin cs = -s0; sn = c0;  end
            2'd2:    begin cs = -c0; sn = -s0; end
            default: begin cs = s0;  sn = -c0; end
        endcase
        w.re = TW'(cs);
        w.im = TW'(-sn);
        return w;
    endfunction

endpackage

// File: rtl/twiddle_mult64_if.sv
// Sample stream interface of twiddle_mult64: input samples with frame restart, output samples with index.
interface twiddle_mult64_if #(
    parameter int DW = fft_pkg::DW
) ();

    logic                 clr;
    logic                 di_en;
    logic signed [DW-1:0] di_re;
    logic signed [DW-1:0] di_im;
    logic                 do_en;
    logic signed [DW-1:0] do_re;
    logic signed [DW-1:0] do_im;
    logic [5:0]           do_idx;

    modport master (output clr, di_en, di_re, di_im, input do_en, do_re, do_im, do_idx);
    modport slave  (input clr, di_en, di_re, di_im, output do_en, do_re, do_im, do_idx);

endinterface

// File: rtl/twiddle_rom64.sv
// 64-entry twiddle ROM, W = exp(-j*2*pi*addr/64) in Q10, with one registered read stage.
module twiddle_rom64
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 en_i,
    input  logic [5:0]           addr_i,
    output logic signed [TW-1:0] tw_re_o,
    output logic signed [TW-1:0] tw_im_o
);

    tw_t rom_q;

    // NOTE: non-blocking assignment for every clocked register so all stages sample pre-edge values.
    // NOTE: ROM read data is pure datapath qualified by the valid pipeline, so it carries no reset.
    always_ff @(posedge clk) begin
        if (en_i) rom_q <= twiddle(addr_i);
    end

    assign tw_re_o = rom_q.re;
    assign tw_im_o = rom_q.im;

endmodule

// File: rtl/twiddle_mult64.sv
// Three-stage complex twiddle multiplier for a 64-point frame; TWM_SAT_EN selects saturation
// instead of wrap when reducing the rounded Q10 result back to DW bits.
module twiddle_mult64
    import fft_pkg::*;
#(
    parameter int DW = fft_pkg::DW,
    parameter int TW = fft_pkg::TW
) (
    input logic             clk,
    input logic             rst_n,
    twiddle_mult64_if.slave bus
);

    localparam int IW = $clog2(N);
    localparam int PW = DW + TW;
    localparam int SW = PW + 1;

`ifdef TWM_SAT_EN
    localparam logic signed [SW-1:0] SMAX = (SW'(1) <<< (DW - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;
`endif

    function automatic logic signed [DW-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef TWM_SAT_EN
        if (v > SMAX)      return DW'(SMAX);
        else if (v < SMIN) return DW'(SMIN);
        else               return DW'(v);
`else
        return DW'(v);
`endif
    endfunction

    logic [IW-1:0] cnt_q, cnt_d, idx_s;
    logic [1:0]    m_s;
    logic [3:0]    k_s;
    logic [5:0]    addr_s;

    logic                 v1_q, v2_q, v3_q;
    logic [IW-1:0]        idx1_q, idx2_q, idx3_q;
    logic signed [DW-1:0] a1_q, b1_q;
    logic signed [TW-1:0] c1, d1;
    logic signed [PW-1:0] ac2_q, bd2_q, ad2_q, bc2_q;
    logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;
    logic signed [DW-1:0] re3_q, im3_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        idx_s = bus.clr ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (bus.clr)        cnt_d = bus.di_en ? IW'(1) : '0;
        else if (bus.di_en) cnt_d = cnt_q + IW'(1);
    end

    // Twiddle exponent uses the bit-reversed top two index bits against the low four.
    assign m_s    = {idx_s[4], idx_s[5]};
    assign k_s    = idx_s[3:0];
    assign addr_s = {4'd0, m_s} * {2'd0, k_s};

    twiddle_rom64 u_rom (
        .clk     (clk),
        .en_i    (bus.di_en),
        .addr_i  (addr_s),
        .tw_re_o (c1),
        .tw_im_o (d1)
    );

    always_ff @(posedge clk) begin
        if (bus.di_en) begin
            a1_q   <= bus.di_re;
            b1_q   <= bus.di_im;
            idx1_q <= idx_s;
        end
        if (v1_q) begin
            ac2_q  <= PW'(a1_q) * PW'(c1);
            bd2_q  <= PW'(b1_q) * PW'(d1);
            ad2_q  <= PW'(a1_q) * PW'(d1);
            bc2_q  <= PW'(b1_q) * PW'(c1);
            idx2_q <= idx1_q;
        end
    end

    // Round half toward +inf: bias by one half LSB, then arithmetic shift.
    always_comb begin
        sum_re = SW'(ac2_q) - SW'(bd2_q);
        sum_im = SW'(ad2_q) + SW'(bc2_q);
        rnd_re = (sum_re + SW'(ROUND_ADD)) >>> TW_SHIFT;
        rnd_im = (sum_im + SW'(ROUND_ADD)) >>> TW_SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            idx3_q <= '0;
            re3_q  <= '0;
            im3_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            v1_q  <= bus.di_en;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            if (v2_q) begin
                idx3_q <= idx2_q;
                re3_q  <= reduce(rnd_re);
                im3_q  <= reduce(rnd_im);
            end
        end
    end

    assign bus.do_en  = v3_q;
    assign bus.do_idx = idx3_q;
    assign bus.do_re  = re3_q;
    assign bus.do_im  = im3_q;

endmodule

// File: tb/tb_twiddle_mult64.sv
// Scoreboard bench for twiddle_mult64; expected samples come from a floating-point twiddle model.
module tb_twiddle_mult64;
    import fft_pkg::*;

    typedef struct {
        int     idx;
        cplx_t  val;
        longint cyc;
    } exp_t;

    localparam real PI = 3.141592653589793;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc   = 0;
    int     n_vec = 0;
    int     n_err = 0;
    int     cnt_m = 0;
    exp_t   sb[$];

    twiddle_mult64_if #(.DW(16)) bus ();

    twiddle_mult64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic logic signed [15:0] reduce_m(input longint v);
`ifdef TWM_SAT_EN
        if (v > 32767)  return 16'sd32767;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    function automatic cplx_t model(input int idx, input int a, input int b);
        cplx_t  r;
        int     m, k, addr, c, d;
        real    ang;
        longint pre, pim;
        m    = 2 * ((idx >> 4) & 1) + ((idx >> 5) & 1);
        k    = idx & 15;
        addr = (m * k) % 64;
        ang  = 2.0 * PI * real'(addr) / 64.0;
        c    = rnd(1024.0 * $cos(ang));
        d    = -rnd(1024.0 * $sin(ang));
        pre  = longint'(a) * c - longint'(b) * d;
        pim  = longint'(a) * d + longint'(b) * c;
        r.re = reduce_m((pre + 512) >>> 10);
        r.im = reduce_m((pim + 512) >>> 10);
        return r;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic drive(input bit en, input bit c, input int re, input int im);
        exp_t e;
        int   idx;
        @(negedge clk);
        bus.di_en = en;
        bus.clr   = c;
        bus.di_re = 16'(re);
        bus.di_im = 16'(im);
        if (c) begin
            idx   = 0;
            cnt_m = en ? 1 : 0;
        end else begin
            idx = cnt_m;
            if (en) cnt_m = (cnt_m + 1) % 64;
        end
        if (en) begin
            e.idx = idx;
            e.val = model(idx, re, im);
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   exp_en;
        if (rst_n) begin
            exp_en = (sb.size() > 0) && (sb[0].cyc + 3 == cyc);
            check("do_en", bus.do_en, exp_en);
            if (exp_en) begin
                e = sb.pop_front();
                check("do_idx", bus.do_idx, e.idx);
                check("do_re", $signed(bus.do_re), e.val.re);
                check("do_im", $signed(bus.do_im), e.val.im);
            end
        end
    end

    initial begin
        bus.clr   = 1'b0;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;
        #12;
        check("rst_do_en", bus.do_en, 0);
        check("rst_do_re", bus.do_re, 0);
        check("rst_do_im", bus.do_im, 0);
        check("rst_do_idx", bus.do_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame of constant (1000,0) after a lone clr
        drive(0, 1, 0, 0);
        for (int i = 0; i < 64; i++) drive(1, 0, 1000, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Rounding: (512,0) at index 0, (1,0) at index 20
        drive(1, 1, 512, 0);
        for (int i = 1; i < 20; i++) drive(1, 0, rnd16(), rnd16());
        drive(1, 0, 1, 0);
        drive(0, 0, 0, 0);

        // Extreme input at index 20 exercises saturation or wrap
        drive(1, 1, rnd16(), rnd16());
        for (int i = 1; i < 20; i++) drive(1, 0, rnd16(), rnd16());
        drive(1, 0, 32767, -32768);
        drive(0, 0, 0, 0);

        // Gapped input across the 63 -> 0 boundary
        drive(0, 1, 0, 0);
        for (int i = 0; i < 62; i++) drive(1, 0, rnd16(), rnd16());
        drive(1, 0, rnd16(), rnd16());
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, rnd16(), rnd16());
        drive(1, 0, rnd16(), rnd16());
        drive(0, 0, 0, 0);

        // clr together with di_en while earlier samples are in flight
        drive(1, 0, rnd16(), rnd16());
        drive(1, 0, rnd16(), rnd16());
        drive(1, 0, rnd16(), rnd16());
        drive(1, 1, rnd16(), rnd16());
        drive(1, 0, rnd16(), rnd16());
        drive(0, 0, 0, 0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 4; i++) drive(1, 0, rnd16(), rnd16());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.di_en = 1'b0;
        #1;
        check("mid_rst_do_en", bus.do_en, 0);
        check("mid_rst_do_re", bus.do_re, 0);
        check("mid_rst_do_im", bus.do_im, 0);
        check("mid_rst_do_idx", bus.do_idx, 0);
        sb.delete();
        cnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 0, rnd16(), rnd16());
        drive(0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
